// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, types and helpers for the seven-segment scan controller
package display_pkg;

    localparam int SCAN_DIV_DEFAULT     = 25000;
    localparam int BLANK_CYCLES_DEFAULT = 500;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic {
        PH_BLANK,
        PH_ON
    } slot_phase_t;

    // Patterns are {g,f,e,d,c,b,a}; a 0 bit lights that segment.
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;

    // True when digit k and every digit to its left hold zero; digit 0 never qualifies.
    function automatic logic lead_zero(input logic [15:0] v, input digit_idx_t k);
        case (k)
            2'd3:    lead_zero = (v[15:12] == 4'h0);
            2'd2:    lead_zero = (v[15:8] == 8'h00);
            2'd1:    lead_zero = (v[15:4] == 12'h000);
            default: lead_zero = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low seven-segment pattern
module hex_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - four-digit seven-segment scan scheduler with frame-aligned value update
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading-zero digits.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = SCAN_DIV_DEFAULT,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        disp_en,
    input  logic [15:0] value_in,
    input  logic        value_valid,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        f,
    output logic        g,
    output logic        d0,
    output logic        d1,
    output logic        d2,
    output logic        d3,
    output logic        frame_start,
    output logic        update_pending
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    logic [CW-1:0] slot_cnt, slot_nxt;
    digit_idx_t    digit_idx, digit_nxt;
    logic [15:0]   shadow, shadow_nxt;
    logic [15:0]   pending, pending_nxt;
    logic          pend_flag, pend_flag_nxt;
    logic          boundary;
    slot_phase_t   phase_nxt;
    logic          suppress;
    logic [3:0]    nibble;
    logic [6:0]    seg_dec;
    logic [6:0]    seg_nxt, seg_q;
    logic [3:0]    dig_nxt, dig_q;
    logic          frame_q;

    // Slot and digit counters; the wrap out of digit 3 is the frame boundary.
    always_comb begin
        boundary  = (slot_cnt == SLOT_LAST) && (digit_idx == 2'd3);
        slot_nxt  = slot_cnt + CW'(1);
        digit_nxt = digit_idx;
        if (slot_cnt == SLOT_LAST) begin
            slot_nxt  = '0;
            digit_nxt = digit_idx + 2'd1;
        end
    end

    // Double buffer: a strobe on the boundary edge bypasses pending entirely.
    always_comb begin
        shadow_nxt    = shadow;
        pending_nxt   = pending;
        pend_flag_nxt = pend_flag;
        if (boundary) begin
            if (value_valid) begin
                shadow_nxt    = value_in;
                pending_nxt   = value_in;
                pend_flag_nxt = 1'b0;
            end else if (pend_flag) begin
                shadow_nxt    = pending;
                pend_flag_nxt = 1'b0;
            end
        end else if (value_valid) begin
            pending_nxt   = value_in;
            pend_flag_nxt = 1'b1;
        end
    end

    assign nibble = shadow_nxt[{digit_nxt, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    // Outputs are computed from the state being entered so the registers line up with it.
    always_comb begin
        phase_nxt = (slot_nxt < BLANK_END) ? PH_BLANK : PH_ON;
`ifdef LEADING_ZERO_BLANK_EN
        suppress  = lead_zero(shadow_nxt, digit_nxt);
`else
        suppress  = 1'b0;
`endif
        seg_nxt   = SEG_OFF;
        dig_nxt   = 4'hF;
        if (disp_en && (phase_nxt == PH_ON) && !suppress) begin
            seg_nxt = seg_dec;
            dig_nxt = ~(4'b0001 << digit_nxt);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt  <= SLOT_LAST;
            digit_idx <= 2'd3;
            shadow    <= '0;
            pending   <= '0;
            pend_flag <= 1'b0;
            seg_q     <= SEG_OFF;
            dig_q     <= 4'hF;
            frame_q   <= 1'b0;
        end else begin
            slot_cnt  <= slot_nxt;
            digit_idx <= digit_nxt;
            shadow    <= shadow_nxt;
            pending   <= pending_nxt;
            pend_flag <= pend_flag_nxt;
            seg_q     <= seg_nxt;
            dig_q     <= dig_nxt;
            frame_q   <= boundary;
        end
    end

    assign {g, f, e, d, c, b, a} = seg_q;
    assign {d3, d2, d1, d0}      = dig_q;
    assign frame_start           = frame_q;
    assign update_pending        = pend_flag;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - scoreboard bench for display_scan_ctrl (SCAN_DIV=8, BLANK_CYCLES=2)
module tb_display_scan_ctrl;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int ON_LEN = SD - BC;
    localparam int FRAME = 4 * SD;

    logic        clock;
    logic        reset_n;
    logic        disp_en;
    logic [15:0] value_in;
    logic        value_valid;
    logic        a, b, c, d, e, f, g;
    logic        d0, d1, d2, d3;
    logic        frame_start;
    logic        update_pending;

    display_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .disp_en        (disp_en),
        .value_in       (value_in),
        .value_valid    (value_valid),
        .a              (a),
        .b              (b),
        .c              (c),
        .d              (d),
        .e              (e),
        .f              (f),
        .g              (g),
        .d0             (d0),
        .d1             (d1),
        .d2             (d2),
        .d3             (d3),
        .frame_start    (frame_start),
        .update_pending (update_pending)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct packed {
        logic [3:0] dig;
        logic [6:0] seg;
        logic [7:0] len;
    } run_t;

    run_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Segment letters lit for each hex glyph, written out by hand.
    function automatic string glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = "abcdef";
            4'h1: glyph = "bc";
            4'h2: glyph = "abdeg";
            4'h3: glyph = "abcdg";
            4'h4: glyph = "bcfg";
            4'h5: glyph = "acdfg";
            4'h6: glyph = "acdefg";
            4'h7: glyph = "abc";
            4'h8: glyph = "abcdefg";
            4'h9: glyph = "abcdfg";
            4'hA: glyph = "abcefg";
            4'hB: glyph = "cdefg";
            4'hC: glyph = "adef";
            4'hD: glyph = "bcdeg";
            4'hE: glyph = "adefg";
            default: glyph = "aefg";
        endcase
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        string s;
        logic [6:0] r;
        s = glyph(n);
        r = 7'h7F;
        for (int i = 0; i < s.len(); i++) r[s[i] - 8'd97] = 1'b0;
        return r;
    endfunction

    task automatic push_digit(input int k, input logic [3:0] nib);
        run_t r;
        r.dig = 4'hF & ~(4'b0001 << k);
        r.seg = seg_of(nib);
        r.len = 8'(ON_LEN);
        exp_q.push_back(r);
    endtask

    task automatic push_frame(input logic [15:0] v);
        for (int k = 0; k < 4; k++) begin
`ifdef LEADING_ZERO_BLANK_EN
            if (k > 0 && (v >> (4 * k)) == 16'h0) continue;
`endif
            push_digit(k, v[4*k +: 4]);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!frame_start && n < 100);
        check("frame_start_wait", frame_start, 1'b1);
    endtask

    task automatic strobe(input logic [15:0] v);
        value_in    = v;
        value_valid = 1'b1;
        @(negedge clock);
        value_valid = 1'b0;
    endtask

    // Monitor: frame spacing, single-digit exclusivity, and lit-run scoreboard.
    logic [3:0] run_dig;
    logic [6:0] run_seg;
    int         run_len = 0;
    bit         run_glitch = 1'b0;
    int         fs_gap = -1;

    always @(negedge clock) begin : monitor
        logic [3:0] dig;
        logic [6:0] seg;
        run_t       r;
        dig = {d3, d2, d1, d0};
        seg = {g, f, e, d, c, b, a};
        if (!reset_n) begin
            run_len    = 0;
            run_glitch = 1'b0;
            fs_gap     = -1;
        end else begin
            if (fs_gap >= 0) fs_gap++;
            if (frame_start) begin
                if (fs_gap >= 0) check("frame_period", fs_gap, FRAME);
                fs_gap = 0;
            end
            if (dig != 4'hF) check("single_digit", $onehot(~dig), 1'b1);
            if (!mon_en) begin
                run_len    = 0;
                run_glitch = 1'b0;
            end else if (dig != 4'hF) begin
                if (run_len == 0) begin
                    run_dig = dig;
                    run_seg = seg;
                end else if (dig != run_dig || seg != run_seg) begin
                    run_glitch = 1'b1;
                end
                run_len++;
            end else if (run_len > 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_run", {run_dig, run_seg}, 11'h7FF);
                end else begin
                    r = exp_q.pop_front();
                    check("lit_run", {run_glitch, run_dig, run_seg, 8'(run_len)},
                          {1'b0, r.dig, r.seg, r.len});
                end
                run_len    = 0;
                run_glitch = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int bad;
        reset_n     = 1'b0;
        disp_en     = 1'b1;
        value_valid = 1'b0;
        value_in    = 16'h0;
        cyc(3);
        check("reset_outputs", {a, b, c, d, e, f, g, d0, d1, d2, d3}, 11'h7FF);
        check("reset_frame_start", frame_start, 1'b0);
        check("reset_pending", update_pending, 1'b0);

        // Frame 1: shadow still zero; capture 0x1234 mid-frame.
        reset_n = 1'b1;
        @(negedge clock);
        check("first_frame_start", frame_start, 1'b1);
        push_frame(16'h0000);
        strobe(16'h1234);
        check("pending_after_strobe", update_pending, 1'b1);

        // Frame 2: 0x1234 shown; 0xABCD captured at cycle 10 waits for the boundary.
        wait_fs();
        push_frame(16'h1234);
        check("pending_cleared_f2", update_pending, 1'b0);
        cyc(9);
        strobe(16'hABCD);
        check("pending_abcd", update_pending, 1'b1);
        cyc(21);
        check("pending_held_to_end", update_pending, 1'b1);

        // Frame 3: ABCD shown; two strobes, last one wins.
        wait_fs();
        push_frame(16'hABCD);
        check("pending_cleared_f3", update_pending, 1'b0);
        cyc(2);
        strobe(16'h1111);
        cyc(16);
        strobe(16'h2222);
        check("pending_2222", update_pending, 1'b1);

        // Frame 4: 2222 shown; strobe exactly on the boundary edge.
        wait_fs();
        push_frame(16'h2222);
        cyc(31);
        check("pending_before_boundary", update_pending, 1'b0);
        value_in    = 16'h5A5A;
        value_valid = 1'b1;
        wait_fs();
        value_valid = 1'b0;
        check("pending_boundary_strobe", update_pending, 1'b0);

        // Frame 5: 5A5A shown immediately; disp_en low for 40 cycles from cycle 12.
        push_digit(0, 4'hA);
        cyc(9);
        mon_en = 1'b0;
        cyc(3);
        disp_en = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clock);
            if ({a, b, c, d, e, f, g, d0, d1, d2, d3} !== 11'h7FF) bad++;
        end
        disp_en = 1'b1;
        check("disp_en_dark_cycles", bad, 0);

        // Frame 7: display resumes; capture 0x0007.
        wait_fs();
        mon_en = 1'b1;
        push_frame(16'h5A5A);
        cyc(4);
        strobe(16'h0007);

        // Frame 8: 0007 shown; capture 0x0050.
        wait_fs();
        push_frame(16'h0007);
        cyc(4);
        strobe(16'h0050);

        // Frame 9: 0050 shown; capture 0x9999 then reset during digit 1 ON.
        wait_fs();
        push_digit(0, 4'h0);
        cyc(4);
        strobe(16'h9999);
        check("pending_9999", update_pending, 1'b1);
        cyc(4);
        mon_en = 1'b0;
        cyc(3);
        check("d1_lit_before_reset", d1, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {a, b, c, d, e, f, g, d0, d1, d2, d3}, 11'h7FF);
        check("async_reset_pending", update_pending, 1'b0);
        check("async_reset_frame_start", frame_start, 1'b0);
        cyc(2);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Frame 10: pending 0x9999 was discarded, shadow back to zero.
        wait_fs();
        push_frame(16'h0000);
        check("pending_after_reset", update_pending, 1'b0);

        wait_fs();
        cyc(2);
        check("exp_queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
